// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core. Instructions and data share one req/ready memory port;
// each instruction walks FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
module multi_cycle_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic              retire,
  output logic              illegal,
  input  logic [4:0]        dbg_reg_addr,
  output logic [31:0]       dbg_reg_data
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] ir_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] alu_out_reg;
  logic [31:0] mdr_reg;
  logic [31:0] target_reg;
  logic        retire_reg;
  logic        illegal_reg;
  logic [31:0] rf_reg [32];

  // Instruction field decode from the latched IR
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [31:0] imm_sext;

  assign op       = ir_reg[31:26];
  assign rs       = ir_reg[25:21];
  assign rt       = ir_reg[20:16];
  assign rd       = ir_reg[15:11];
  assign shamt    = ir_reg[10:6];
  assign funct    = ir_reg[5:0];
  assign imm_sext = {{16{ir_reg[15]}}, ir_reg[15:0]};

  logic is_rtype;
  logic is_addi;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic r_legal;
  logic legal;

  assign is_rtype = (op == OP_RTYPE);
  assign is_addi  = (op == OP_ADDI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);

  always_comb begin
    r_legal = 1'b0;
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL: r_legal = 1'b1;
      default: r_legal = 1'b0;
    endcase
  end

  assign legal = (is_rtype && r_legal) || is_addi || is_lw || is_sw || is_beq;

  // ALU: I-formats (addi/lw/sw) all reduce to A + sext(imm)
  logic [31:0] alu_result;

  always_comb begin
    alu_result = a_reg + imm_sext;
    if (is_rtype) begin
      case (funct)
        FN_ADD:  alu_result = a_reg + b_reg;
        FN_SUB:  alu_result = a_reg - b_reg;
        FN_AND:  alu_result = a_reg & b_reg;
        FN_OR:   alu_result = a_reg | b_reg;
        FN_SLT:  alu_result = {31'd0, $signed(a_reg) < $signed(b_reg)};
        FN_SLL:  alu_result = b_reg << shamt;
        FN_SRL:  alu_result = b_reg >> shamt;
        default: alu_result = a_reg + b_reg;
      endcase
    end
  end

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;

  assign pc_plus4      = pc_reg + 32'd4;
  assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};

  // Bus is a pure function of the held state/regs, so it stays stable across wait states.
  // Gating with rst drops a stalled access the moment reset is applied.
  logic [31:0] bus_addr;

  assign bus_addr  = (state_reg == S_MEM) ? alu_out_reg : pc_reg;
  assign mem_addr  = bus_addr[ADDR_W-1:0];
  assign mem_req   = !rst && ((state_reg == S_FETCH) || (state_reg == S_MEM));
  assign mem_we    = !rst && (state_reg == S_MEM) && is_sw;
  assign mem_wdata = b_reg;

  assign pc      = pc_reg;
  assign retire  = retire_reg;
  assign illegal = illegal_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      pc_reg      <= RESET_PC;
      ir_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      alu_out_reg <= '0;
      mdr_reg     <= '0;
      target_reg  <= '0;
      retire_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      retire_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      case (state_reg)
        S_FETCH: begin
          if (mem_ready) begin
            ir_reg    <= mem_rdata;
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_reg      <= rf_reg[rs];
          b_reg      <= rf_reg[rt];
          target_reg <= branch_target;
          if (!legal) begin
            retire_reg  <= 1'b1;
            illegal_reg <= 1'b1;
            pc_reg      <= pc_plus4;
            state_reg   <= S_FETCH;
          end else begin
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_out_reg <= alu_result;
          if (is_beq) begin
            pc_reg     <= (a_reg == b_reg) ? target_reg : pc_plus4;
            retire_reg <= 1'b1;
            state_reg  <= S_FETCH;
          end else if (is_lw || is_sw) begin
            state_reg <= S_MEM;
          end else begin
            state_reg <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_sw) begin
              retire_reg <= 1'b1;
              pc_reg     <= pc_plus4;
              state_reg  <= S_FETCH;
            end else begin
              mdr_reg   <= mem_rdata;
              state_reg <= S_WB;
            end
          end
        end
        S_WB: begin
          retire_reg <= 1'b1;
          pc_reg     <= pc_plus4;
          state_reg  <= S_FETCH;
        end
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  // Register file; $0 is never written so it reads back as zero
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        wb_en;

  assign wb_dest = is_rtype ? rd : rt;
  assign wb_data = is_lw ? mdr_reg : alu_out_reg;
  assign wb_en   = (state_reg == S_WB) && (wb_dest != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_reg[i] <= '0;
      end
    end else if (wb_en) begin
      rf_reg[wb_dest] <= wb_data;
    end
  end

  assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? 32'd0 : rf_reg[dbg_reg_addr];

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed bench for multi_cycle_cpu: word memory model with per-access wait states on data addresses.
module tb_multi_cycle_cpu;

  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] pc;
  logic        retire;
  logic        illegal;
  logic [4:0]  dbg_reg_addr = 5'd0;
  logic [31:0] dbg_reg_data;

  always #5 clk = ~clk;

  multi_cycle_cpu dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .pc           (pc),
    .retire       (retire),
    .illegal      (illegal),
    .dbg_reg_addr (dbg_reg_addr),
    .dbg_reg_data (dbg_reg_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Memory model: addresses >= 0x40 are data and take wait_cfg stall cycles per access
  logic [31:0] mem [256];
  logic        clr_mem    = 1'b0;
  logic        load_en    = 1'b0;
  logic [7:0]  load_idx   = 8'd0;
  logic [31:0] load_data  = 32'd0;
  int          wait_cfg   = 0;
  int          wait_cnt   = 0;
  logic [31:0] last_waddr = 32'd0;
  logic [31:0] last_wdata = 32'd0;

  assign mem_ready = (mem_addr < 32'h40) || (wait_cnt == 0);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    end else if (load_en) begin
      mem[load_idx] <= load_data;
    end else if (mem_req && mem_ready && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      last_waddr         <= mem_addr;
      last_wdata         <= mem_wdata;
    end
    if (rst) wait_cnt <= wait_cfg;
    else if (mem_req && !mem_ready) wait_cnt <= wait_cnt - 1;
    else if (mem_req) wait_cnt <= wait_cfg;
  end

  // Bus must hold still through every wait cycle of an access
  logic        chk_stable = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_addr  = 32'd0;
  logic [31:0] prev_wdata = 32'd0;
  logic        prev_we    = 1'b0;

  always @(negedge clk) begin
    if (chk_stable && stall_prev && mem_req) begin
      check("stall_addr", mem_addr, prev_addr);
      check("stall_we", 32'(mem_we), 32'(prev_we));
      check("stall_wdata", mem_wdata, prev_wdata);
    end
    stall_prev <= mem_req && !mem_ready;
    prev_addr  <= mem_addr;
    prev_we    <= mem_we;
    prev_wdata <= mem_wdata;
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh,
                                        input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input int r, output logic [31:0] v);
    dbg_reg_addr = 5'(r);
    #1;
    v = dbg_reg_data;
  endtask

  // Counts edges until the next retire pulse; bounded
  task automatic retire_wait(output int n);
    for (n = 1; n <= 64; n++) begin
      tick();
      if (retire) break;
    end
    if (!retire) check("retire_seen", 32'(retire), 32'd1);
  endtask

  logic [31:0] prog [$];

  // Leaves rst asserted; caller releases it
  task automatic start_prog(input int wcfg);
    rst     = 1'b1;
    clr_mem = 1'b1;
    tick();
    clr_mem = 1'b0;
    load_en = 1'b1;
    foreach (prog[i]) begin
      load_idx  = 8'(i);
      load_data = prog[i];
      tick();
    end
    load_en  = 1'b0;
    wait_cfg = wcfg;
    tick();
  endtask

  task automatic poke(input int idx, input logic [31:0] data);
    load_en   = 1'b1;
    load_idx  = 8'(idx);
    load_data = data;
    tick();
    load_en   = 1'b0;
  endtask

  initial begin
    int          n;
    logic [31:0] v;
    logic [31:0] t;

    // Reset state and first addi
    prog = {};
    prog.push_back(enc_i(OP_ADDI, 0, 1, 5));
    start_prog(0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    rst = 1'b0;
    #1;
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", mem_addr, 32'd0);
    retire_wait(n);
    check("addi_latency", n, 32'd4);
    check("addi_pc", pc, 32'd4);
    rd_reg(1, v);
    check("addi_r1", v, 32'd5);

    // R-type arithmetic
    prog = {};
    prog.push_back(enc_i(OP_ADDI, 0, 1, 7));
    prog.push_back(enc_i(OP_ADDI, 0, 2, -3));
    prog.push_back(enc_r(1, 2, 3, 0, 6'b100000));   // add  $3,$1,$2
    prog.push_back(enc_r(2, 1, 4, 0, 6'b100010));   // sub  $4,$2,$1
    prog.push_back(enc_r(2, 1, 5, 0, 6'b101010));   // slt  $5,$2,$1
    prog.push_back(enc_r(0, 1, 6, 4, 6'b000000));   // sll  $6,$1,4
    prog.push_back(enc_r(1, 2, 8, 0, 6'b100100));   // and  $8,$1,$2
    prog.push_back(enc_r(1, 2, 9, 0, 6'b100101));   // or   $9,$1,$2
    prog.push_back(enc_r(0, 2, 10, 28, 6'b000010)); // srl  $10,$2,28
    prog.push_back(enc_r(1, 2, 11, 0, 6'b101010));  // slt  $11,$1,$2
    start_prog(0);
    rst = 1'b0;
    retire_wait(n);
    retire_wait(n);
    retire_wait(n);
    check("rtype_latency", n, 32'd4);
    for (int k = 0; k < 7; k++) retire_wait(n);
    rd_reg(2, v);  check("r2_neg3", v, 32'hFFFF_FFFD);
    rd_reg(3, v);  check("add_r3", v, 32'd4);
    rd_reg(4, v);  check("sub_r4", v, 32'hFFFF_FFF6);
    rd_reg(5, v);  check("slt_r5", v, 32'd1);
    rd_reg(6, v);  check("sll_r6", v, 32'd112);
    rd_reg(8, v);  check("and_r8", v, 32'd5);
    rd_reg(9, v);  check("or_r9", v, 32'hFFFF_FFFF);
    rd_reg(10, v); check("srl_r10", v, 32'h0000_000F);
    rd_reg(11, v); check("slt_r11", v, 32'd0);

    // sw/lw with 3 wait states on each data access
    prog = {};
    prog.push_back(enc_i(OP_ADDI, 0, 1, 7));
    prog.push_back(enc_i(OP_SW, 0, 1, 64));
    prog.push_back(enc_i(OP_LW, 0, 7, 64));
    start_prog(3);
    chk_stable = 1'b1;
    rst = 1'b0;
    retire_wait(n);
    check("ws_addi_latency", n, 32'd4);
    retire_wait(n);
    check("sw_latency", n, 32'd7);
    check("sw_addr", last_waddr, 32'h40);
    check("sw_wdata", last_wdata, 32'd7);
    retire_wait(n);
    check("lw_latency", n, 32'd8);
    chk_stable = 1'b0;
    rd_reg(7, v);
    check("lw_r7", v, 32'd7);

    // beq taken: self-loop at 0x20
    prog = {};
    prog.push_back(enc_i(OP_ADDI, 0, 1, 1));
    prog.push_back(enc_i(OP_ADDI, 0, 2, 2));
    for (int k = 0; k < 6; k++) prog.push_back(32'd0);
    prog.push_back(enc_i(OP_BEQ, 1, 1, -1));
    start_prog(0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) retire_wait(n);
    for (int k = 0; k < 3; k++) begin
      retire_wait(n);
      check("beq_taken_latency", n, 32'd3);
      check("beq_taken_pc", pc, 32'h20);
    end

    // beq not taken
    prog[8] = enc_i(OP_BEQ, 1, 2, -1);
    start_prog(0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) retire_wait(n);
    retire_wait(n);
    check("beq_nt_latency", n, 32'd3);
    check("beq_nt_pc", pc, 32'h24);

    // Illegal encodings and $0 writes
    prog = {};
    prog.push_back(32'hFC00_0000);
    prog.push_back(enc_i(OP_ADDI, 0, 0, 9));
    prog.push_back(enc_r(0, 0, 4, 0, 6'b100000));   // add $4,$0,$0
    prog.push_back(enc_i(OP_ADDI, 0, 3, 1));
    prog.push_back(enc_r(1, 1, 3, 0, 6'b100001));   // addu: unsupported
    start_prog(0);
    rst = 1'b0;
    retire_wait(n);
    check("ill_latency", n, 32'd2);
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_pc", pc, 32'd4);
    retire_wait(n);
    check("addi_r0_latency", n, 32'd4);
    check("addi_r0_flag", 32'(illegal), 32'd0);
    retire_wait(n);
    retire_wait(n);
    retire_wait(n);
    check("ill_r_flag", 32'(illegal), 32'd1);
    tick();
    check("ill_pulse_end", 32'(illegal), 32'd0);
    rd_reg(0, v); check("r0_zero", v, 32'd0);
    rd_reg(4, v); check("r0_reads_zero", v, 32'd0);
    rd_reg(3, v); check("ill_no_write_r3", v, 32'd1);

    // Reset during a stalled lw
    prog = {};
    prog.push_back(enc_i(OP_ADDI, 0, 1, 5));
    prog.push_back(enc_i(OP_LW, 0, 7, 64));
    start_prog(10);
    poke(16, 32'h0000_1234);
    rst = 1'b0;
    retire_wait(n);
    repeat (4) tick();
    check("lw_stall_req", 32'(mem_req), 32'd1);
    check("lw_stall_addr", mem_addr, 32'h40);
    rst = 1'b1;
    tick();
    check("abort_req", 32'(mem_req), 32'd0);
    check("abort_pc", pc, 32'd0);
    v = 32'd0;
    for (int r = 0; r < 32; r++) begin
      rd_reg(r, t);
      v = v | t;
    end
    check("abort_regs_zero", v, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("restart_req", 32'(mem_req), 32'd1);
    check("restart_addr", mem_addr, 32'd0);
    retire_wait(n);
    check("restart_latency", n, 32'd4);
    rd_reg(1, v);
    check("restart_r1", v, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
